// File: rtl/cofi_pkg.sv
// Shared sizing helpers for the cofi_mc scanline blender: fixed-point fraction
// width, pipeline latency and the timing bundle carried alongside the pixels.
package cofi_pkg;

  typedef int cofi_width_t;

  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hs;
    logic vs;
  } cofi_sync_t;

  function automatic cofi_width_t frac_bits(input cofi_width_t coeff_w);
    return coeff_w + 1;
  endfunction

  function automatic cofi_width_t cofi_lat(input cofi_width_t order);
    return order + 1;
  endfunction

  // Signed step error needs one bit of headroom over the unsigned accumulator.
  function automatic cofi_width_t delta_bits(input cofi_width_t depth, input cofi_width_t coeff_w);
    return depth + frac_bits(coeff_w) + 1;
  endfunction

endpackage

// File: rtl/cofi_mc_stage.sv
// One low-pass pole for a single colour channel: reseed to the input, or move
// a coeff/2^FRAC fraction of the remaining error on each filter step.
module cofi_mc_stage
  import cofi_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int COEFF_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               reseed,
  input  logic [COEFF_W-1:0] coeff,
  input  logic [DEPTH-1:0]   x,
  output logic [DEPTH-1:0]   y
);

  localparam int FRAC  = frac_bits(COEFF_W);
  localparam int ACC_W = DEPTH + FRAC;
  localparam int DLT_W = delta_bits(DEPTH, COEFF_W);
  localparam int PRD_W = DLT_W + COEFF_W + 1;

  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        target;
  logic signed [DLT_W-1:0] delta;
  logic signed [PRD_W-1:0] delta_x;
  logic signed [PRD_W-1:0] coeff_x;
  logic signed [PRD_W-1:0] prod;
  logic [ACC_W-1:0]        incr;

  assign target  = {x, {FRAC{1'b0}}};
  assign delta   = $signed({1'b0, target}) - $signed({1'b0, acc});
  assign delta_x = PRD_W'(delta);
  assign coeff_x = $signed(PRD_W'(coeff));
  assign prod    = delta_x * coeff_x;

  // Gain is below one, so the new value always lies between acc and target and
  // the modular add of the truncated (floored) increment is exact.
  assign incr    = ACC_W'(prod >>> FRAC);
  assign y       = acc[ACC_W-1:FRAC];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       acc <= '0;
    else if (reseed) acc <= target;
    else if (step)   acc <= acc + incr;
  end

endmodule

// File: rtl/cofi_mc.sv
// Multi-channel scanline IIR blender: per-channel pole stages sharing one step
// counter and a frame-shadowed coefficient, with sync delayed to match pixels.
module cofi_mc
  import cofi_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NCH     = 3,
  parameter int COEFF_W = 4,
  parameter int ORDER   = 1,
  parameter int DIV_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COEFF_W-1:0]   coeff_in,
  input  logic [DIV_W-1:0]     step_div,
  input  logic                 hblank,
  input  logic                 vblank,
  input  logic                 hs,
  input  logic                 vs,
  input  logic [NCH*DEPTH-1:0] pix_in,
  output logic                 hblank_out,
  output logic                 vblank_out,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic [NCH*DEPTH-1:0] pix_out
);

  localparam int LAT = cofi_lat(ORDER);

  logic [DIV_W-1:0]   cnt;
  logic [DIV_W-1:0]   div_lim;
  logic [COEFF_W-1:0] coeff_q;
  logic               vblank_d;
  logic               step;
  logic               reseed;
  logic [DEPTH-1:0]   stage_y [NCH*ORDER];
  cofi_sync_t         sync_pipe [LAT];

  assign div_lim = (step_div > DIV_W'(1)) ? step_div - DIV_W'(1) : '0;
  assign step    = (cnt == '0) && !hblank;
  assign reseed  = hblank || (coeff_q == '0);

  // cnt counts clocks since the last step; a limit lowered below cnt wraps at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cnt <= '0;
    else if (hblank)         cnt <= '0;
    else if (cnt >= div_lim) cnt <= '0;
    else                     cnt <= cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_d <= 1'b0;
      coeff_q  <= '0;
    end else begin
      vblank_d <= vblank;
      if (vblank && !vblank_d) coeff_q <= coeff_in;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    for (genvar s = 0; s < ORDER; s++) begin : g_st
      logic [DEPTH-1:0] stage_x;

      if (s == 0) begin : g_first
        assign stage_x = pix_in[ch*DEPTH +: DEPTH];
      end else begin : g_chain
        assign stage_x = stage_y[ch*ORDER + s - 1];
      end

      cofi_mc_stage #(
        .DEPTH  (DEPTH),
        .COEFF_W(COEFF_W)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .reseed(reseed),
        .coeff (coeff_q),
        .x     (stage_x),
        .y     (stage_y[ch*ORDER + s])
      );
    end
  end

  // Sync travels through LAT registers so it lines up with pix_out in every mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_out <= '0;
      for (int i = 0; i < LAT; i++) sync_pipe[i] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) pix_out[c*DEPTH +: DEPTH] <= stage_y[c*ORDER + ORDER - 1];
      sync_pipe[0] <= {hblank, vblank, hs, vs};
      for (int i = 1; i < LAT; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign hblank_out = sync_pipe[LAT-1].hblank;
  assign vblank_out = sync_pipe[LAT-1].vblank;
  assign hs_out     = sync_pipe[LAT-1].hs;
  assign vs_out     = sync_pipe[LAT-1].vs;

endmodule

// File: tb/tb_cofi_mc.sv
// Bench for cofi_mc: directed vector tables for step, shadow, decimation and
// reseed cases, then random scanlines against a behavioural filter model.
module tb_cofi_mc;

  typedef struct {
    logic       hb;
    logic [7:0] px;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  coeff_in;
  logic [1:0]  step_div;
  logic        hblank, vblank, hs, vs;
  logic [23:0] pix_in;
  logic        hb1, vb1, hs1, vs1;
  logic        hb2, vb2, hs2, vs2;
  logic [23:0] pix1, pix2;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: [order-1][channel][stage]
  int          m_acc [2][3][2];
  int          m_gain;
  logic        m_vb_prev;
  int          m_idx;
  logic [23:0] m_exp_pix [2];
  logic [3:0]  m_sync_q [$];

  always #5 clk = ~clk;

  cofi_mc #(.DEPTH(8), .NCH(3), .COEFF_W(4), .ORDER(1), .DIV_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .coeff_in(coeff_in), .step_div(step_div),
    .hblank(hblank), .vblank(vblank), .hs(hs), .vs(vs), .pix_in(pix_in),
    .hblank_out(hb1), .vblank_out(vb1), .hs_out(hs1), .vs_out(vs1), .pix_out(pix1)
  );

  cofi_mc #(.DEPTH(8), .NCH(3), .COEFF_W(4), .ORDER(2), .DIV_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .coeff_in(coeff_in), .step_div(step_div),
    .hblank(hblank), .vblank(vblank), .hs(hs), .vs(vs), .pix_in(pix_in),
    .hblank_out(hb2), .vblank_out(vb2), .hs_out(hs2), .vs_out(vs2), .pix_out(pix2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int floor_div32(input int a);
    if (a >= 0) return a / 32;
    return -((-a + 31) / 32);
  endfunction

  function automatic logic [3:0] exp_sync(input int lat);
    return (m_sync_q.size() >= lat) ? m_sync_q[lat-1] : 4'b0;
  endfunction

  function automatic void model_reset();
    for (int o = 0; o < 2; o++)
      for (int c = 0; c < 3; c++)
        for (int s = 0; s < 2; s++) m_acc[o][c][s] = 0;
    m_gain = 0;
    m_vb_prev = 1'b0;
    m_idx = 0;
    m_exp_pix[0] = '0;
    m_exp_pix[1] = '0;
    m_sync_q.delete();
  endfunction

  // One clock of the filter as described: reseed, otherwise step every div clocks.
  function automatic void model_edge();
    int  div, x, y0_prev, d;
    bit  rs, st;
    div = (step_div < 2'd2) ? 1 : int'(step_div);
    rs  = hblank || (m_gain == 0);
    st  = !hblank && ((m_idx % div) == 0);
    for (int o = 0; o < 2; o++) begin
      for (int c = 0; c < 3; c++) begin
        m_exp_pix[o][c*8 +: 8] = 8'(m_acc[o][c][o] / 32);
        y0_prev = m_acc[o][c][0] / 32;
        for (int s = 0; s <= o; s++) begin
          x = (s == 0) ? int'(pix_in[c*8 +: 8]) : y0_prev;
          if (rs) m_acc[o][c][s] = x * 32;
          else if (st) begin
            d = x * 32 - m_acc[o][c][s];
            m_acc[o][c][s] = m_acc[o][c][s] + floor_div32(d * m_gain);
          end
        end
      end
    end
    m_idx = hblank ? 0 : m_idx + 1;
    if (vblank && !m_vb_prev) m_gain = int'(coeff_in);
    m_vb_prev = vblank;
    m_sync_q.push_front({hblank, vblank, hs, vs});
    if (m_sync_q.size() > 3) void'(m_sync_q.pop_back());
  endfunction

  task automatic applyStimulus(input logic hb, input logic vb, input logic [23:0] px);
    hblank = hb;
    vblank = vb;
    pix_in = px;
    hs = 1'($urandom);
    vs = 1'($urandom);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checkOutput("model_pix_o1", 32'(pix1), 32'(m_exp_pix[0]));
    checkOutput("model_pix_o2", 32'(pix2), 32'(m_exp_pix[1]));
    checkOutput("model_sync_o1", 32'({hb1, vb1, hs1, vs1}), 32'(exp_sync(2)));
    checkOutput("model_sync_o2", 32'({hb2, vb2, hs2, vs2}), 32'(exp_sync(3)));
    checkOutput("model_acc_ch0", 32'(u_dut1.g_ch[0].g_st[0].u_stage.acc), 32'(m_acc[0][0][0]));
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    checkOutput("reset_pix_o1", 32'(pix1), 32'd0);
    checkOutput("reset_pix_o2", 32'(pix2), 32'd0);
    checkOutput("reset_sync_o1", 32'({hb1, vb1, hs1, vs1}), 32'd0);
    checkOutput("reset_sync_o2", 32'({hb2, vb2, hs2, vs2}), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [6];
    int          dec_exp [5];
    logic [23:0] ramp [16];
    logic [23:0] cur;
    int          hb_len, act_len;

    coeff_in = '0; step_div = 2'd1;
    hblank = 1'b1; vblank = 1'b0; hs = 1'b0; vs = 1'b0; pix_in = '0;

    vecs[0] = '{1'b1, 8'd0,   8'd0,   8'd0};
    vecs[1] = '{1'b0, 8'd255, 8'd0,   8'd0};
    vecs[2] = '{1'b0, 8'd255, 8'd63,  8'd0};
    vecs[3] = '{1'b0, 8'd255, 8'd111, 8'd15};
    vecs[4] = '{1'b0, 8'd255, 8'd147, 8'd39};
    vecs[5] = '{1'b0, 8'd255, 8'd174, 8'd66};
    dec_exp = '{0, 63, 63, 111, 111};

    #2;
    doReset();

    // Bypass: no vblank edge since reset, so coeff_in is ignored.
    coeff_in = 4'd5;
    for (int i = 0; i < 16; i++) begin
      ramp[i] = {8'(i*7 + 3), 8'(i*5 + 1), 8'(i*11)};
      applyStimulus((i % 5) == 4, 1'b0, ramp[i]);
      if (i >= 1) checkOutput("bypass_o1", 32'(pix1), 32'(ramp[i-1]));
      if (i >= 2) checkOutput("bypass_o2", 32'(pix2), 32'(ramp[i-2]));
    end

    // Load gain 8/32 with the vblank edge landing inside hblank.
    coeff_in = 4'd8;
    step_div = 2'd1;
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].hb, 1'b0, {3{vecs[i].px}});
      checkOutput("step_o1", 32'(pix1), 32'({3{vecs[i].e1}}));
      checkOutput("step_o2", 32'(pix2), 32'({3{vecs[i].e2}}));
    end

    // Reseed: settle on 200, then one hblank clock at 10 must leave no residue.
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, {3{8'd200}});
    applyStimulus(1'b1, 1'b0, {3{8'd10}});
    applyStimulus(1'b0, 1'b0, {3{8'd10}});
    checkOutput("reseed_first_o1", 32'(pix1), 32'({3{8'd10}}));
    applyStimulus(1'b0, 1'b0, {3{8'd10}});
    checkOutput("reseed_hold_o1", 32'(pix1), 32'({3{8'd10}}));

    // Shadowing: coeff_in drops to 3 mid-line, gain stays 8 until vblank rises.
    coeff_in = 4'd3;
    applyStimulus(1'b0, 1'b0, {3{8'd10}});
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, {3{8'd255}});
    checkOutput("shadow_start_o1", 32'(pix1), 32'd0);
    applyStimulus(1'b0, 1'b0, {3{8'd255}});
    checkOutput("shadow_hold_o1", 32'(pix1), 32'({3{8'd63}}));
    applyStimulus(1'b1, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, {3{8'd255}});
    checkOutput("shadow_new_start_o1", 32'(pix1), 32'd0);
    applyStimulus(1'b0, 1'b0, {3{8'd255}});
    checkOutput("shadow_new_o1", 32'(pix1), 32'({3{8'd23}}));

    // Decimation by 2 at gain 8.
    coeff_in = 4'd8;
    step_div = 2'd2;
    applyStimulus(1'b1, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("dec_cnt_first", 32'(u_dut1.cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, {3{8'd255}});
      if (i == 0) checkOutput("dec_cnt_second", 32'(u_dut1.cnt), 32'd1);
      checkOutput("dec_o1", 32'(pix1), 32'({3{8'(dec_exp[i])}}));
    end

    // Reset mid-line: outputs clear at once and bypass follows.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, {3{8'd90}});
    doReset();
    applyStimulus(1'b0, 1'b0, {3{8'd77}});
    checkOutput("post_reset_o1", 32'(pix1), 32'd0);
    applyStimulus(1'b0, 1'b0, {3{8'd77}});
    checkOutput("post_reset_bypass_o1", 32'(pix1), 32'({3{8'd77}}));
    applyStimulus(1'b0, 1'b0, {3{8'd77}});
    checkOutput("post_reset_bypass_o2", 32'(pix2), 32'({3{8'd77}}));

    // Random scanlines against the model.
    cur = 24'($urandom);
    for (int line = 0; line < 40; line++) begin
      hb_len   = $urandom_range(2, 5);
      act_len  = $urandom_range(4, 24);
      step_div = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) coeff_in = 4'($urandom);
      for (int i = 0; i < hb_len; i++)
        applyStimulus(1'b1, ((line % 4) == 0) && (i == 1), 24'($urandom));
      for (int i = 0; i < act_len; i++) begin
        if ($urandom_range(0, 9) == 0) coeff_in = 4'($urandom);
        if ($urandom_range(0, 3) == 0) cur = 24'($urandom);
        applyStimulus(1'b0, $urandom_range(0, 39) == 0, cur);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
